// File: rtl/ikascc_pkg.sv
// Shared types, widths and the 16-bit saturation helper for the SCC sound path.
package ikascc_pkg;

    localparam int SCC_SND_W = 11;
    localparam int PCM_W     = 16;

    typedef logic signed [PCM_W-1:0] pcm_t;

    // Clamp a wide signed value into the signed 16-bit PCM range.
    function automatic pcm_t sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/ikascc_pcm_fifo.sv
// Small output FIFO for decimated PCM samples.
// Push and pop are both registered, there is no empty-bypass path, and dout reads 0 while empty.
module ikascc_pcm_fifo #(
    parameter int W    = 16,
    parameter int LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LOG2:0] count
);

    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem_q [DEPTH];
    logic [LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LOG2:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full  = (cnt_q == (LOG2+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_q];

    // When full, a push only lands if a pop frees the head slot on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next-state for the pointers (wrap naturally at DEPTH) and the occupancy count.
    always_comb begin
        wr_d  = wr_q + LOG2'(do_push);
        rd_d  = rd_q + LOG2'(do_pop);
        cnt_d = cnt_q + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; the count gates what is visible at dout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/ikascc_sound_decimator.sv
// Box-car decimator for the SCC sound output: averages 2^DECIM_LOG2 samples,
// rescales to 16 bits with a power-of-two gain and saturation, and queues the result.
module ikascc_sound_decimator
    import ikascc_pkg::*;
#(
    parameter int DECIM_LOG2 = 6,
    parameter int GAIN_LOG2  = 0,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    input  logic                 i_MCLK_PCEN_n,
    input  logic                 i_EN,
    input  logic [SCC_SND_W-1:0] i_SOUND,
    output logic [PCM_W-1:0]     o_SAMPLE,
    output logic                 o_VALID,
    input  logic                 i_READY,
    output logic                 o_OVF,
    input  logic                 i_OVF_CLR
);

    // Accumulator is wide enough that a full window of extreme samples cannot overflow.
    localparam int AW = SCC_SND_W + DECIM_LOG2;

    logic signed [AW-1:0]   acc_q, acc_d, sum;
    logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
    logic                   push;
    logic                   ovf_q, ovf_d;
    logic signed [PCM_W-1:0] scaled;
    logic signed [31:0]     wide;
    pcm_t                   pcm;
    logic                   fifo_full, fifo_empty, pop;
    logic [FIFO_LOG2:0]     fifo_cnt;

    assign sum = acc_q + AW'($signed(i_SOUND));

    // Window sequencing: accumulate on enabled cycles, emit and restart at the last sample.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (!i_EN) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (!i_MCLK_PCEN_n) begin
            if (cnt_q == '1) begin
                acc_d = '0;
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Map the AW-bit sum onto 16 bits so full-scale input lands at 16-bit full scale.
    generate
        if (AW >= PCM_W) begin : g_shr
            logic signed [AW-1:0] shr;
            assign shr    = sum >>> (AW - PCM_W);
            assign scaled = shr[PCM_W-1:0];
        end else begin : g_shl
            assign scaled = {sum, {(PCM_W-AW){1'b0}}};
        end
    endgenerate

    assign wide = 32'(scaled) <<< GAIN_LOG2;
    assign pcm  = sat16(wide);

    assign pop     = ~fifo_empty & i_READY;
    assign o_VALID = |fifo_cnt;

    // Sticky overflow: set when a window result is dropped; a clear request takes priority.
    always_comb begin
        ovf_d = ovf_q;
        if (i_OVF_CLR) begin
            ovf_d = 1'b0;
        end else if (push & fifo_full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    // Accumulator, phase counter and overflow registers.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_OVF = ovf_q;

    ikascc_pcm_fifo #(
        .W    (PCM_W),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (i_EMUCLK),
        .rst   (i_RST),
        .push  (push),
        .pop   (pop),
        .din   (pcm),
        .dout  (o_SAMPLE),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_ikascc_sound_decimator.sv
// Randomised/directed bench for the SCC sound decimator, checked against a window/queue reference model.
module tb_ikascc_sound_decimator;

    localparam int N     = 64;  // samples per window at DECIM_LOG2 = 6
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b0, pcen_n = 1'b1, en = 1'b0, ready = 1'b0, ovf_clr = 1'b0;
    logic [10:0] snd = '0;
    logic [15:0] s0, s1;
    logic        v0, v1, o0, o1;

    int nchk = 0, nerr = 0;
    int cyc = 0, ramp = 0;
    bit rdy_rand = 0;

    // reference model state
    int wsum = 0, wn = 0;
    int q0[$], q1[$];
    bit ovf0 = 0, ovf1 = 0;
    bit m_push, m_pop, m_full, m_drop;
    int m_smp;

    always #5 clk = ~clk;

    ikascc_sound_decimator dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n), .i_EN(en), .i_SOUND(snd),
        .o_SAMPLE(s0), .o_VALID(v0), .i_READY(ready), .o_OVF(o0), .i_OVF_CLR(ovf_clr)
    );

    ikascc_sound_decimator #(.GAIN_LOG2(1)) dut_g1 (
        .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n), .i_EN(en), .i_SOUND(snd),
        .o_SAMPLE(s1), .o_VALID(v1), .i_READY(ready), .o_OVF(o1), .i_OVF_CLR(ovf_clr)
    );

    // window average of 64 11-bit samples -> 16 bits is floor(sum/2), then gain and clamp
    function automatic int scale(int sum, int g);
        int s;
        s = (sum >= 0) ? sum / 2 : -((-sum + 1) / 2);
        s = s * (1 << g);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // reference model: windows of N enabled samples feeding a DEPTH-entry queue
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wsum = 0; wn = 0; q0.delete(); q1.delete(); ovf0 = 0; ovf1 = 0;
        end else begin
            m_push = 0; m_drop = 0; m_smp = 0;
            m_pop  = (q0.size() != 0) && ready;
            m_full = (q0.size() == DEPTH);
            if (!en) begin
                wsum = 0; wn = 0;
            end else if (!pcen_n) begin
                wsum = wsum + int'($signed(snd));
                wn = wn + 1;
                if (wn == N) begin
                    m_push = 1; m_smp = wsum; wsum = 0; wn = 0;
                end
            end
            if (m_pop) begin
                void'(q0.pop_front()); void'(q1.pop_front());
            end
            if (m_push) begin
                if (m_full && !m_pop) m_drop = 1;
                else begin
                    q0.push_back(scale(m_smp, 0));
                    q1.push_back(scale(m_smp, 1));
                end
            end
            if (ovf_clr) begin ovf0 = 0; ovf1 = 0; end
            else if (m_drop) begin ovf0 = 1; ovf1 = 1; end
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, act, exp);
        end
    endtask

    // advance to the next falling edge and compare both DUTs against the model
    task automatic step();
        @(negedge clk);
        chk("valid",     int'(v0), int'(q0.size() != 0));
        chk("sample",    int'($signed(s0)), (q0.size() != 0) ? q0[0] : 0);
        chk("ovf",       int'(o0), int'(ovf0));
        chk("valid_g1",  int'(v1), int'(q1.size() != 0));
        chk("sample_g1", int'($signed(s1)), (q1.size() != 0) ? q1[0] : 0);
        chk("ovf_g1",    int'(o1), int'(ovf1));
    endtask

    // mode 0: hold snd, enable every 4th clock; 1: ramp; 2: random enable and sample
    task automatic drive(input int mode);
        cyc++;
        pcen_n = (cyc % 4 != 0);
        if (mode == 2) pcen_n = 1'($urandom_range(0, 1));
        if (!pcen_n) begin
            if (mode == 1) begin snd = 11'(ramp % N); ramp++; end
            else if (mode == 2) snd = 11'($urandom);
        end
        if (rdy_rand) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) begin step(); drive(mode); end
    endtask

    // drop i_EN for a cycle so the next window starts aligned
    task automatic restart();
        step(); en = 1'b0; drive(0);
        step(); en = 1'b1; drive(0);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        #12;
        chk("rst_valid", int'(v0), 0);
        chk("rst_sample", int'(s0), 0);
        chk("rst_ovf", int'(o0), 0);
        rst = 1'b0;

        // full-scale positive
        en = 1'b1; snd = 11'd1023; ready = 1'b0;
        run(260, 0);
        chk("pos_fs", int'($signed(s0)), 32736);
        chk("pos_fs_g1", int'($signed(s1)), 32767);
        ready = 1'b1;
        run(300, 0);

        // full-scale negative
        snd = 11'h400; ready = 1'b0;
        restart();
        run(260, 0);
        chk("neg_fs", int'($signed(s0)), -32768);
        chk("neg_fs_g1", int'($signed(s1)), -32768);
        ready = 1'b1;
        run(10, 0);

        // ramp 0..63
        ramp = 0; ready = 1'b0;
        restart();
        run(260, 1);
        chk("ramp", int'($signed(s0)), 1008);
        ready = 1'b1;
        run(10, 1);

        // random samples, enables and back-pressure
        rdy_rand = 1;
        run(3000, 2);
        rdy_rand = 0; ready = 1'b1;
        run(20, 0);

        // overflow with consumer stalled for six windows
        snd = 11'($urandom); ready = 1'b0;
        restart();
        run(6 * 256 + 10, 0);
        chk("ovf_set", int'(o0), 1);
        chk("ovf_held_valid", int'(v0), 1);
        step(); ovf_clr = 1'b1; drive(0);
        step(); ovf_clr = 1'b0; drive(0);
        chk("ovf_clr", int'(o0), 0);
        ready = 1'b1;
        run(10, 0);

        // full FIFO with a pop on the same edge as a window end
        snd = 11'($urandom); ready = 1'b0;
        restart();
        run(4 * 256 + 10, 0);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step(); drive(0);
            if (en && !pcen_n && wn == N - 1) begin ready = 1'b1; hit = 1; end
        end
        chk("coin_hit", int'(hit), 1);
        step(); ready = 1'b0;
        chk("coin_ovf", int'(o0), 0);
        chk("coin_valid", int'(v0), 1);

        // asynchronous reset in the middle of a window, FIFO occupied
        run(100, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(v0), 0);
        chk("arst_sample", int'(s0), 0);
        chk("arst_ovf", int'(o0), 0);
        #1 rst = 1'b0;
        ready = 1'b1;
        run(600, 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
